// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_ACCEPT,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_ADDR,
    R_DATA
  } rd_state_e;

  // Works on the widest legal bus (64 bits); narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_d,
                                             input logic [63:0] new_d,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// Register storage with byte-strobe merge; wr_pulse_o exists only when
// AXIL_REGS_WR_PULSE_EN is defined.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                N_REGS    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                IDX_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATA_W-1:0]        data,
  input  logic [DATA_W/8-1:0]      strb,
  output logic [N_REGS*DATA_W-1:0] regs_o
`ifdef AXIL_REGS_WR_PULSE_EN
  ,
  output logic [N_REGS-1:0]        wr_pulse_o
`endif
);

  logic [DATA_W-1:0] mem [N_REGS];

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0]   old_d,
                                                   input logic [DATA_W-1:0]   new_d,
                                                   input logic [DATA_W/8-1:0] s);
    logic [63:0] o64, n64, r64;
    logic [7:0]  s8;
    o64 = '0;
    n64 = '0;
    s8  = '0;
    o64[DATA_W-1:0]   = old_d;
    n64[DATA_W-1:0]   = new_d;
    s8[DATA_W/8-1:0]  = s;
    r64 = strb_merge(o64, n64, s8);
    return r64[DATA_W-1:0];
  endfunction

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < N_REGS; i++) mem[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (we && idx == IDX_W'(i)) mem[i] <= merge_word(mem[i], data, strb);
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = mem[g];
  end

`ifdef AXIL_REGS_WR_PULSE_EN
  // Pulse lines up with the first BVALID cycle; an all-zero strobe is not a write.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_pulse_o <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        wr_pulse_o[i] <= we && (|strb) && (idx == IDX_W'(i));
      end
    end
  end
`endif

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave over N_REGS control registers, independent read/write FSMs.
// Optional per-register write strobe output enabled by AXIL_REGS_WR_PULSE_EN.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                N_REGS    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axi_lite_if.slave                S_AXI_LITE,
  output logic [N_REGS*DATA_W-1:0] regs_o
`ifdef AXIL_REGS_WR_PULSE_EN
  ,
  output logic [N_REGS-1:0]        wr_pulse_o
`endif
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam int BI_W     = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return 64'(idx) < 64'(N_REGS);
  endfunction

  wr_state_e           wr_state, wr_next;
  logic                aw_got, w_got;
  logic                aw_rdy, w_rdy, aw_hs, w_hs;
  logic [IDX_W-1:0]    aw_idx;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                b_valid;
  resp_e               b_resp;
  logic                wr_in_range, wr_en;

  rd_state_e           rd_state, rd_next;
  logic                ar_rdy, ar_hs;
  logic [IDX_W-1:0]    ar_idx;
  logic [DATA_W-1:0]   rd_word, r_data;
  resp_e               r_resp;
  logic                r_valid;

  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_LITE.awaddr[ADDR_LSB-1:0], S_AXI_LITE.araddr[ADDR_LSB-1:0]};

  // Write FSM
  always_comb begin
    wr_next = wr_state;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    case (wr_state)
      W_ACCEPT: begin
        aw_rdy = !aw_got;
        w_rdy  = !w_got;
        aw_hs  = S_AXI_LITE.awvalid && aw_rdy;
        w_hs   = S_AXI_LITE.wvalid && w_rdy;
        if ((aw_got || aw_hs) && (w_got || w_hs)) wr_next = W_COMMIT;
      end
      W_COMMIT: wr_next = W_RESP;
      W_RESP:   if (S_AXI_LITE.bready) wr_next = W_ACCEPT;
      default:  wr_next = W_ACCEPT;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= W_ACCEPT;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) aw_got <= 1'b1;
      if (w_hs)  w_got  <= 1'b1;
      if (wr_state == W_COMMIT) begin
        b_valid <= 1'b1;
        b_resp  <= wr_in_range ? OKAY : SLVERR;
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
      end
      if (wr_state == W_RESP && S_AXI_LITE.bready) b_valid <= 1'b0;
    end
  end

  // Capture registers carry no state of their own; the got flags qualify them.
  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_idx <= S_AXI_LITE.awaddr[ADDR_W-1:ADDR_LSB];
    if (w_hs) begin
      w_data <= S_AXI_LITE.wdata;
      w_strb <= S_AXI_LITE.wstrb;
    end
  end

  assign wr_in_range = idx_ok(aw_idx);
  assign wr_en       = (wr_state == W_COMMIT) && wr_in_range;

  axi_lite_reg_bank #(
    .DATA_W    (DATA_W),
    .N_REGS    (N_REGS),
    .RESET_VAL (RESET_VAL),
    .IDX_W     (BI_W)
  ) u_bank (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .we         (wr_en),
    .idx        (aw_idx[BI_W-1:0]),
    .data       (w_data),
    .strb       (w_strb),
    .regs_o     (regs_o)
`ifdef AXIL_REGS_WR_PULSE_EN
    ,
    .wr_pulse_o (wr_pulse_o)
`endif
  );

  // Read FSM; the mux yields zero for out-of-range indices.
  assign ar_idx = S_AXI_LITE.araddr[ADDR_W-1:ADDR_LSB];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (64'(ar_idx) == 64'(i)) rd_word = regs_o[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_next = rd_state;
    ar_rdy  = 1'b0;
    ar_hs   = 1'b0;
    case (rd_state)
      R_ADDR: begin
        ar_rdy = 1'b1;
        ar_hs  = S_AXI_LITE.arvalid;
        if (ar_hs) rd_next = R_DATA;
      end
      R_DATA:  if (S_AXI_LITE.rready) rd_next = R_ADDR;
      default: rd_next = R_ADDR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= R_ADDR;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_resp   <= OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        r_valid <= 1'b1;
        r_data  <= rd_word;
        r_resp  <= idx_ok(ar_idx) ? OKAY : SLVERR;
      end else if (rd_state == R_DATA && S_AXI_LITE.rready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign S_AXI_LITE.awready = aw_rdy;
  assign S_AXI_LITE.wready  = w_rdy;
  assign S_AXI_LITE.bvalid  = b_valid;
  assign S_AXI_LITE.bresp   = b_resp;
  assign S_AXI_LITE.arready = ar_rdy;
  assign S_AXI_LITE.rvalid  = r_valid;
  assign S_AXI_LITE.rdata   = r_data;
  assign S_AXI_LITE.rresp   = r_resp;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: vector table with a response scoreboard plus
// hand-built corner sequences; pulse checks when AXIL_REGS_WR_PULSE_EN is defined.
module tb_axi_lite_reg_slave;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          N_REGS = 16;
  localparam logic [31:0] RST_V  = 32'hA5A5_0000;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic [N_REGS*DATA_W-1:0] regs_o;
`ifdef AXIL_REGS_WR_PULSE_EN
  logic [N_REGS-1:0] wr_pulse_o;
`endif

  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  axi_lite_reg_slave #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .N_REGS    (N_REGS),
    .RESET_VAL (RST_V)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .S_AXI_LITE (bus),
    .regs_o     (regs_o)
`ifdef AXIL_REGS_WR_PULSE_EN
    ,
    .wr_pulse_o (wr_pulse_o)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  eresp;
    logic [31:0] edata;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb_q[$];
  logic [31:0] model[N_REGS];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return regs_o[i*DATA_W +: DATA_W];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[31:2]);
    if (idx < N_REGS) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic wait_b(output logic [1:0] resp, output bit ok);
    ok = 1'b0;
    resp = 2'b11;
    bus.bready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.bvalid) begin
        resp = bus.bresp;
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit ok);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int n = 0; n < 20 && (bus.awvalid || bus.wvalid); n++) begin
      logic a, w;
      a = bus.awready;
      w = bus.wready;
      tick();
      if (a) bus.awvalid = 1'b0;
      if (w) bus.wvalid  = 1'b0;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    wait_b(resp, ok);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit ok);
    ok = 1'b0;
    data = '0;
    resp = 2'b11;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    for (int n = 0; n < 20 && bus.arvalid; n++) begin
      logic a;
      a = bus.arready;
      tick();
      if (a) bus.arvalid = 1'b0;
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (bus.rvalid) begin
        data = bus.rdata;
        resp = bus.rresp;
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdat;
    bit          ok;
    bit          bseen;
    logic [1:0]  bresp_s;
    exp_t        e;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0;  bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < N_REGS; i++) model[i] = RST_V;

    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[2]  = '{1'b1, 32'h0000_000C, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hFF11_2233, 4'h8, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'hFFA5_0000};
    vecs[6]  = '{1'b1, 32'h0000_003C, 32'hDEAD_0000, 4'h0, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 2'b00, 32'hA5A5_0000};
    vecs[8]  = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0005, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};

    // Reset state
    ARESETn = 1'b0;
    tick(); tick(); tick();
    ARESETn = 1'b1;
    #1;
    for (int i = 0; i < N_REGS; i++) check($sformatf("rst_reg%0d", i), word(i), RST_V);
    check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, {4'b0000, 32'h0});
`ifdef AXIL_REGS_WR_PULSE_EN
    check("rst_pulse", wr_pulse_o, 16'h0);
`endif
    tick();

    // Same-cycle AW+W write, latency of BVALID
    bus.awaddr = 32'h08; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    check("wr_lat_c1_bvalid", bus.bvalid, 1'b0);
    check("wr_lat_c1_reg2", word(2), RST_V);
    tick();
    check("wr_lat_c2", {bus.bvalid, bus.bresp}, 3'b100);
    check("wr_lat_c2_reg2", word(2), 32'hDEAD_BEEF);
    tick();
    check("wr_lat_c3_bvalid", bus.bvalid, 1'b0);
    bus.bready = 0;
    model[2] = 32'hDEAD_BEEF;
    do_read(32'h08, rdat, resp, ok);
    check("rd_after_wr", {ok, resp, rdat}, {1'b1, 2'b00, 32'hDEAD_BEEF});

    // W three cycles ahead of AW, partial strobe
    bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101; bus.wvalid = 1;
    tick();
    bus.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w_first_rdy%0d", i), {bus.awready, bus.wready}, 2'b10);
      if (i == 2) begin
        bus.awaddr = 32'h08;
        bus.awvalid = 1;
      end
      tick();
    end
    bus.awvalid = 0;
    wait_b(resp, ok);
    check("w_first_bresp", {ok, resp}, 3'b100);
    check("w_first_reg2", word(2), 32'hDE22_BE44);
    model_write(32'h08, 32'h1122_3344, 4'b0101);

    // Vector table through the scoreboard
    foreach (vecs[k]) begin
      sb_q.push_back('{vecs[k].wr, vecs[k].eresp, vecs[k].edata});
      if (vecs[k].wr) begin
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, resp, ok);
        if (vecs[k].eresp == 2'b00) model_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
        rdat = '0;
      end else begin
        do_read(vecs[k].addr, rdat, resp, ok);
      end
      e = sb_q.pop_front();
      check($sformatf("vec%0d_done", k), ok, 1'b1);
      if (e.wr) check($sformatf("vec%0d_bresp", k), resp, e.resp);
      else      check($sformatf("vec%0d_rd", k), {resp, rdat}, {e.resp, e.data});
    end
    for (int i = 0; i < N_REGS; i++) check($sformatf("bank_reg%0d", i), word(i), model[i]);

    // Read backpressure with a concurrent write to another register
    bus.araddr = 32'h0C; bus.arvalid = 1; bus.rready = 0;
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      logic a;
      a = bus.arready;
      tick();
      if (a) begin
        ok = 1;
        break;
      end
    end
    bus.arvalid = 0;
    check("bp_ar_hs", ok, 1'b1);
    bus.awaddr = 32'h14; bus.wdata = 32'h55AA_55AA; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
    bseen = 0; bresp_s = 2'b11;
    for (int i = 0; i < 5; i++) begin
      logic a, w;
      check($sformatf("bp_hold%0d", i), {bus.rvalid, bus.arready, bus.rresp, bus.rdata},
            {1'b1, 1'b0, 2'b00, 32'h1234_5678});
      if (bus.bvalid && !bseen) begin
        bseen = 1;
        bresp_s = bus.bresp;
      end
      a = bus.awready;
      w = bus.wready;
      tick();
      if (a) bus.awvalid = 0;
      if (w) bus.wvalid = 0;
    end
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
    check("bp_wr_resp", {bseen, bresp_s}, 3'b100);
    model_write(32'h14, 32'h55AA_55AA, 4'hF);
    check("bp_wr_reg5", word(5), model[5]);
    bus.rready = 1;
    tick();
    bus.rready = 0;
    check("bp_release", {bus.rvalid, bus.arready}, 2'b01);

    // Reset during the commit cycle
    bus.awaddr = 32'h18; bus.wdata = 32'h0BAD_0BAD; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; bus.bready = 0;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    ARESETn = 0;
    tick();
    check("rstc_bvalid_in_rst", bus.bvalid, 1'b0);
    tick();
    ARESETn = 1;
    #1;
    for (int i = 0; i < N_REGS; i++) model[i] = RST_V;
    check("rstc_reg6", word(6), RST_V);
    check("rstc_state", {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, 5'b00111);
    tick(); tick();
    check("rstc_later", {bus.bvalid, word(6)}, {1'b0, RST_V});
    do_write(32'h18, 32'h600D_600D, 4'hF, resp, ok);
    check("rstc_wr_after", {ok, resp}, 3'b100);
    do_read(32'h18, rdat, resp, ok);
    check("rstc_rd_after", {ok, resp, rdat}, {1'b1, 2'b00, 32'h600D_600D});
    model[6] = 32'h600D_600D;

`ifdef AXIL_REGS_WR_PULSE_EN
    begin
      int          npulse;
      logic [15:0] pval, p_at_b;
      npulse = 0; pval = '0; p_at_b = '0; bseen = 0;
      bus.awaddr = 32'h0C; bus.wdata = 32'h0000_0333; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
      for (int i = 0; i < 6; i++) begin
        logic a, w;
        if (wr_pulse_o != 16'h0) begin
          npulse++;
          pval = wr_pulse_o;
        end
        if (bus.bvalid && !bseen) begin
          bseen = 1;
          p_at_b = wr_pulse_o;
        end
        a = bus.awready;
        w = bus.wready;
        tick();
        if (a) bus.awvalid = 0;
        if (w) bus.wvalid = 0;
      end
      bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
      check("pulse_count", npulse, 1);
      check("pulse_value", pval, 16'h0008);
      check("pulse_at_bvalid", {bseen, p_at_b}, {1'b1, 16'h0008});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- Parametrised AXI4-Lite slave terminating a bank of N_REGS memory-mapped control registers.
- Read and write paths are independent FSMs and run concurrently.
- AW and W channels are accepted in either order or in the same cycle. WSTRB byte enables are honoured.
- Out-of-range addresses return SLVERR.
- Sits between the AXI-Lite interconnect and block-level control logic. Replaces the fixed single-FSM slave.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; legal values 32 or 64.
- N_REGS, 16, number of registers; range 1..2**(ADDR_W-ADDR_LSB).
- RESET_VAL, '0, DATA_W-bit reset value of every register.

Ports:
- ACLK  input  1  clock; all logic rising-edge.
- ARESETn  input  1  asynchronous active-low reset.
- S_AXI_LITE  interface  -  axi_lite_if.slave modport, parametrised #(ADDR_W, DATA_W); WSTRB is DATA_W/8 bits.
- regs_o  output  N_REGS*DATA_W  flat register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_pulse_o  output  N_REGS  one-cycle write strobe per register (only when AXIL_REGS_WR_PULSE_EN is defined).

Behaviour:
- Address decoding:
  - ADDR_LSB = clog2(DATA_W/8).
  - idx = addr[ADDR_W-1:ADDR_LSB]; addr[ADDR_LSB-1:0] is ignored.
  - idx >= N_REGS means out of range.
- Reset: all registers = RESET_VAL. AWREADY, WREADY and ARREADY = 1 on the first cycle after release. BVALID, RVALID and wr_pulse_o = 0. RDATA = 0. BRESP and RRESP = OKAY.
- Reset mid-transaction: in-flight transactions are dropped with no write commit and no response. Both FSMs return to idle.
- Write FSM: W_ACCEPT -> W_COMMIT -> W_RESP.
  - W_ACCEPT:
    - AWREADY = !aw_got; WREADY = !w_got.
    - An AW handshake captures AWADDR and sets aw_got. A W handshake captures WDATA and WSTRB and sets w_got.
    - Both handshakes may occur in the same cycle.
    - Go to W_COMMIT on the edge where aw_got and w_got become (or already are) both set.
  - W_COMMIT (1 cycle, AWREADY = WREADY = 0):
    - In range: for each byte b with strb[b] = 1, reg[idx][8b+:8] <= data[8b+:8]. Bytes with strb = 0 are unchanged.
    - Out of range: no register changes.
    - BVALID goes to 1 on the same edge. BRESP = OKAY (2'b00), or SLVERR (2'b10) if out of range. Clear aw_got and w_got.
  - W_RESP: hold BVALID and BRESP until BREADY; on handshake return to W_ACCEPT.
  - The new register value is visible on regs_o in the first cycle BVALID = 1.
  - Minimum write cost: 3 cycles per transaction (AW+W same cycle, BREADY held high).
- Read FSM: R_ADDR -> R_DATA.
  - R_ADDR: ARREADY = 1. On handshake:
    - RDATA <= reg[idx]; RRESP <= OKAY.
    - If out of range, RDATA <= 0 and RRESP <= SLVERR.
    - RVALID <= 1; go to R_DATA.
  - R_DATA: ARREADY = 0. RDATA and RRESP are held stable until RREADY; on handshake, RVALID <= 0 and return to R_ADDR.
  - Throughput: one read per 2 cycles.
- Simultaneous read and write to the same register:
  - The read samples the value present at the AR-handshake edge.
  - A commit on the same edge is not seen; the old value is returned.
- VALID-before-READY and READY-before-VALID are both legal. The slave never withdraws VALID before the handshake.

Optional Feature:
- Macro: AXIL_REGS_WR_PULSE_EN.
- Defined: wr_pulse_o exists. wr_pulse_o[idx] = 1 for exactly the cycle after the W_COMMIT edge, i.e. the first BVALID cycle. It is asserted only for in-range writes with any strobe bit set. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- axi_lite_pkg gains:
  - resp_e: OKAY = 2'b00, SLVERR = 2'b10.
  - wr_state_e: W_ACCEPT, W_COMMIT, W_RESP.
  - rd_state_e: R_ADDR, R_DATA.
  - strb_merge function (old, new, strb).
- Sub-module axi_lite_reg_bank (parameters DATA_W, N_REGS, RESET_VAL):
  - Holds storage and the strobe merge.
  - Inputs: write enable, index, data, strb. Outputs: flat regs, and wr_pulse when the macro is defined.
- The top level holds both FSMs, the capture registers and the decode.

Test Plan:
- Reset: after ARESETn deassert with RESET_VAL = 32'hA5A5_0000 -> every regs_o word = 32'hA5A5_0000; BVALID = RVALID = 0; AWREADY = WREADY = ARREADY = 1.
- Write 0x08 = 32'hDEAD_BEEF with strb 4'hF, AW+W same cycle, BREADY = 1 -> BVALID 2 cycles later; BRESP = 00; reg[2] = 32'hDEAD_BEEF; read 0x08 returns the same with RRESP = 00.
- W presented 3 cycles before AW, strb 4'b0101, data 32'h1122_3344 to reg[2] = DEAD_BEEF -> reg[2] = 32'hDE22_BE44; AWREADY stays 1 while WREADY = 0 during the wait.
- Out of range with N_REGS = 16: write 0x40, then read 0x40 -> BRESP = 2'b10, no regs_o change; RRESP = 2'b10, RDATA = 0.
- Backpressure: RREADY low 5 cycles -> RVALID/RDATA stable; ARREADY = 0. Concurrent write to another register completes meanwhile.
- Reset asserted in W_COMMIT cycle -> register keeps prior value; BVALID = 0. With AXIL_REGS_WR_PULSE_EN defined: normal write to reg[3] -> wr_pulse_o = 16'h0008 for exactly 1 cycle.
